// File: rtl/uart_tx_framer.sv
// UART transmit serializer: configurable data/parity/stop bits, valid/ready input.
// Define UART_TX_FIFO_EN to place a FIFO_DEPTH-entry FIFO in front of the framer.
module uart_tx_framer #(
    parameter int SRC_CLOCK  = 0,
    parameter int BAUDS      = 0,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 ser_ck,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] shift_data,
    input  logic                 shift,
    output logic                 ready,
    output logic                 serout,
    output logic                 busy
);

    localparam int TICKS = (BAUDS > 0) ? (SRC_CLOCK / BAUDS) : 0;
    localparam int CW    = (TICKS > 2) ? $clog2(TICKS) : 1;
    localparam logic [CW-1:0] TICK_LAST = CW'(TICKS - 1);

    if (TICKS < 2) begin : g_bad_ticks
        $error("uart_tx_framer: SRC_CLOCK/BAUDS must be >= 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_framer: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_tx_framer: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_tx_framer: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_framer: FIFO_DEPTH must be a power of 2 >= 2");
    end

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t                 state;
    logic [CW-1:0]          baud_cnt;
    logic [3:0]             bit_cnt;
    logic [DATA_BITS-1:0]   sr;
    logic                   par_bit;

    logic                   tick_end;
    logic                   frame_end;
    logic                   load_slot;
    logic                   accept;
    logic                   load;
    logic [DATA_BITS-1:0]   next_word;

    // odd parity is the complement of the even (XOR) parity
    function automatic logic parity_of(input logic [DATA_BITS-1:0] w);
        parity_of = (PARITY == 1) ? ~(^w) : (^w);
    endfunction

    // bit timing and the points where a new word may be loaded
    always_comb begin
        tick_end  = (baud_cnt == TICK_LAST);
        frame_end = (state == STOP) && tick_end && (bit_cnt == 4'(STOP_BITS - 1));
        load_slot = (state == IDLE) || frame_end;
    end

`ifdef UART_TX_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [AW:0]          count;
    logic                 empty;
    logic                 full;
    logic                 push_store;
    logic                 pop;

    // an accept into an empty FIFO at a load slot bypasses storage entirely
    always_comb begin
        empty      = (count == '0);
        full       = (count == (AW+1)'(FIFO_DEPTH));
        ready      = !full && !rst;
        accept     = shift && ready;
        load       = load_slot && (accept || !empty);
        next_word  = empty ? shift_data : mem[rd_ptr];
        pop        = load && !empty;
        push_store = accept && !(load && empty);
    end

    // FIFO pointers and occupancy
    always_ff @(posedge ser_ck or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_store) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + (AW+1)'(push_store) - (AW+1)'(pop);
        end
    end

    // FIFO storage, no reset needed on the data array
    always_ff @(posedge ser_ck) begin
        if (push_store) begin
            mem[wr_ptr] <= shift_data;
        end
    end
`else
    // without a FIFO a word is only taken while idle
    always_comb begin
        ready     = (state == IDLE) && !rst;
        accept    = shift && ready;
        load      = load_slot && accept;
        next_word = shift_data;
    end
`endif

    // frame sequencer with registered line and busy outputs
    always_ff @(posedge ser_ck or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            sr       <= '0;
            par_bit  <= 1'b0;
            serout   <= 1'b1;
            busy     <= 1'b0;
        end else if (load) begin
            state    <= START;
            sr       <= next_word;
            par_bit  <= parity_of(next_word);
            baud_cnt <= '0;
            bit_cnt  <= '0;
            serout   <= 1'b0;
            busy     <= 1'b1;
        end else begin
            if (state == IDLE || tick_end) begin
                baud_cnt <= '0;
            end else begin
                baud_cnt <= baud_cnt + 1'b1;
            end
            case (state)
                IDLE: begin
                    serout <= 1'b1;
                    busy   <= 1'b0;
                end
                START: begin
                    if (tick_end) begin
                        state  <= DATA;
                        serout <= sr[0];
                    end
                end
                DATA: begin
                    if (tick_end) begin
                        if (bit_cnt == 4'(DATA_BITS - 1)) begin
                            bit_cnt <= '0;
                            if (PARITY != 0) begin
                                state  <= PAR;
                                serout <= par_bit;
                            end else begin
                                state  <= STOP;
                                serout <= 1'b1;
                            end
                        end else begin
                            sr      <= sr >> 1;
                            serout  <= sr[1];
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                end
                PAR: begin
                    if (tick_end) begin
                        state   <= STOP;
                        serout  <= 1'b1;
                        bit_cnt <= '0;
                    end
                end
                STOP: begin
                    if (frame_end) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (tick_end) begin
                        bit_cnt <= bit_cnt + 4'd1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    serout <= 1'b1;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_framer.sv
// Directed bench for uart_tx_framer: 8N1, 7E2, 8O1, 8E1 instances at 16 clocks per bit.
module tb_uart_tx_framer;

    localparam int TK = 16;

    logic       ser_ck = 1'b0;
    logic       rst    = 1'b1;
    logic [8:0] tx_data = 9'd0;
    logic [3:0] shift_v = 4'd0;
    logic [3:0] so_v;
    logic [3:0] bz_v;
    logic [3:0] rd_v;
    logic [1:0] sel = 2'd0;
    logic       mon_serout;
    logic       mon_busy;
    logic       mon_ready;

    int errors = 0;
    int checks = 0;

    always #5 ser_ck = ~ser_ck;

    assign mon_serout = so_v[sel];
    assign mon_busy   = bz_v[sel];
    assign mon_ready  = rd_v[sel];

    uart_tx_framer #(.SRC_CLOCK(1600), .BAUDS(100), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
        .ser_ck(ser_ck), .rst(rst), .shift_data(tx_data[7:0]), .shift(shift_v[0]),
        .ready(rd_v[0]), .serout(so_v[0]), .busy(bz_v[0]));
    uart_tx_framer #(.SRC_CLOCK(1600), .BAUDS(100), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u_7e2 (
        .ser_ck(ser_ck), .rst(rst), .shift_data(tx_data[6:0]), .shift(shift_v[1]),
        .ready(rd_v[1]), .serout(so_v[1]), .busy(bz_v[1]));
    uart_tx_framer #(.SRC_CLOCK(1600), .BAUDS(100), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8o1 (
        .ser_ck(ser_ck), .rst(rst), .shift_data(tx_data[7:0]), .shift(shift_v[2]),
        .ready(rd_v[2]), .serout(so_v[2]), .busy(bz_v[2]));
    uart_tx_framer #(.SRC_CLOCK(1600), .BAUDS(100), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
        .ser_ck(ser_ck), .rst(rst), .shift_data(tx_data[7:0]), .shift(shift_v[3]),
        .ready(rd_v[3]), .serout(so_v[3]), .busy(bz_v[3]));

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Sends one word on instance s and checks every clock of the frame; pb is the
    // hand-computed parity bit. p2 > 0 re-pulses shift at that cycle of the frame.
    task automatic send_frame(input int s, input logic [8:0] d, input int nb, input int pe,
                              input logic pb, input int ns, input int p2, input string tag);
        logic [15:0] bits;
        int k;
        int len;
        bits = 16'hFFFF;
        bits[0] = 1'b0;
        for (int i = 0; i < nb; i++) bits[1+i] = d[i];
        k = 1 + nb;
        if (pe != 0) begin
            bits[k] = pb;
            k++;
        end
        len = (k + ns) * TK;
        @(negedge ser_ck);
        sel = 2'(s);
        #1;
        check_eq({tag, " ready_before"}, 32'(mon_ready), 32'd1);
        tx_data = d;
        shift_v[s] = 1'b1;
        for (int c = 0; c < len; c++) begin
            @(negedge ser_ck);
            if (c == 0) shift_v[s] = 1'b0;
            if (p2 > 0 && c == p2 - 1) begin
                check_eq({tag, " ready_mid"}, 32'(mon_ready), 32'd0);
                shift_v[s] = 1'b1;
            end
            if (p2 > 0 && c == p2) shift_v[s] = 1'b0;
            check_eq({tag, " serout"}, 32'(mon_serout), 32'(bits[c / TK]));
            check_eq({tag, " busy"}, 32'(mon_busy), 32'd1);
        end
        @(negedge ser_ck);
        check_eq({tag, " busy_end"}, 32'(mon_busy), 32'd0);
        check_eq({tag, " ready_end"}, 32'(mon_ready), 32'd1);
        for (int c = 0; c < 20; c++) begin
            check_eq({tag, " idle_line"}, 32'(mon_serout), 32'd1);
            check_eq({tag, " idle_busy"}, 32'(mon_busy), 32'd0);
            @(negedge ser_ck);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] w;
        int f;
        int b;
        logic e;
        repeat (3) @(negedge ser_ck);
        check_eq("rst serout", 32'(so_v[0]), 32'd1);
        check_eq("rst busy", 32'(bz_v[0]), 32'd0);
        check_eq("rst ready", 32'(rd_v[0]), 32'd0);
        rst = 1'b0;
        #1;
        check_eq("post_rst ready", 32'(rd_v[0]), 32'd1);

        send_frame(0, 9'h055, 8, 0, 1'b0, 1, 0, "8n1_55");
        send_frame(1, 9'h041, 7, 1, 1'b0, 2, 0, "7e2_41");
        send_frame(2, 9'h000, 8, 1, 1'b1, 1, 0, "8o1_00");
        send_frame(3, 9'h007, 8, 1, 1'b1, 1, 0, "8e1_07");

`ifdef UART_TX_FIFO_EN
        // five pushes on consecutive cycles, expect five contiguous frames
        @(negedge ser_ck);
        sel = 2'd0;
        tx_data = 9'h001;
        shift_v[0] = 1'b1;
        for (int c = 0; c < 5 * 160; c++) begin
            @(negedge ser_ck);
            if (c < 4) begin
                check_eq("fifo ready_push", 32'(mon_ready), 32'd1);
                tx_data = 9'(c + 2);
            end
            if (c == 4) begin
                check_eq("fifo ready_full", 32'(mon_ready), 32'd0);
                shift_v[0] = 1'b0;
            end
            if (c == 160) check_eq("fifo ready_pop", 32'(mon_ready), 32'd1);
            f = c / 160;
            b = (c % 160) / TK;
            w = 8'(f + 1);
            e = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : w[b - 1];
            check_eq("fifo serout", 32'(mon_serout), 32'(e));
            check_eq("fifo busy", 32'(mon_busy), 32'd1);
        end
        @(negedge ser_ck);
        check_eq("fifo busy_end", 32'(mon_busy), 32'd0);
`else
        send_frame(0, 9'h0A5, 8, 0, 1'b0, 1, 5, "nofifo_a5");
`endif

        // reset at clock 40 of a frame while more words are offered
        @(negedge ser_ck);
        sel = 2'd0;
        tx_data = 9'h081;
        shift_v[0] = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge ser_ck);
            if (c == 2) shift_v[0] = 1'b0;
        end
        check_eq("abort pre_line", 32'(mon_serout), 32'd0);
        check_eq("abort pre_busy", 32'(mon_busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_eq("abort serout", 32'(mon_serout), 32'd1);
        check_eq("abort busy", 32'(mon_busy), 32'd0);
        check_eq("abort ready", 32'(mon_ready), 32'd0);
        repeat (2) @(negedge ser_ck);
        rst = 1'b0;
        #1;
        check_eq("abort ready_rel", 32'(mon_ready), 32'd1);
        check_eq("abort busy_rel", 32'(mon_busy), 32'd0);
        send_frame(0, 9'h03C, 8, 0, 1'b0, 1, 0, "after_rst_3c");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
